// File: rtl/ssg_mix_pkg.sv
// Shared types and constants for the SSG channel mixer and its per-channel slices.
package ssg_mix_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      HOLD = 2'd2,
      DOWN = 2'd3
   } ramp_state_e;

   // Per-channel Status field is {enable, noise_sel}
   localparam int ENABLE_BIT = 1;
   localparam int NOISE_BIT  = 0;

   localparam int DEF_SAMPLE_W = 6;
   localparam int DEF_VOL_W    = 4;

endpackage

// File: rtl/ssg_mix_channel.sv
// One mixer channel: source select, click-free gain ramp and scaled sample register.
// Updates only on strobe; one register stage, no backpressure.
module ssg_mix_channel
   import ssg_mix_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int VOL_W    = DEF_VOL_W
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                strobe_i,
   input  logic [SAMPLE_W-1:0] wave_i,
   input  logic [SAMPLE_W-1:0] noise_i,
   input  logic [1:0]          status_i,
   input  logic [VOL_W-1:0]    volume_i,
   output logic [SAMPLE_W-1:0] scaled_o,
   output logic                active_o
);

   localparam int              PROD_W   = SAMPLE_W + VOL_W;
   localparam logic [VOL_W-1:0] GAIN_ONE = {{(VOL_W-1){1'b0}}, 1'b1};

   ramp_state_e         state_q, state_d;
   logic [VOL_W-1:0]    gain_q, gain_d;
   logic [VOL_W-1:0]    target;
   logic [SAMPLE_W-1:0] src;
   logic [SAMPLE_W-1:0] scaled_q, scaled_d;
   logic [PROD_W-1:0]   prod;
   logic                enable, up, down;

   assign enable = status_i[ENABLE_BIT];
   assign target = enable ? volume_i : '0;
   assign up     = target > gain_q;
   assign down   = target < gain_q;

   // Disabling silences the channel at once; the gain ramp only tracks re-enable continuity
   always_comb begin
      src = '0;
      if (enable) begin
         src = status_i[NOISE_BIT] ? noise_i : wave_i;
      end
   end

   assign prod     = {{VOL_W{1'b0}}, src} * {{SAMPLE_W{1'b0}}, gain_q};
   assign scaled_d = prod[PROD_W-1:VOL_W];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else if (strobe_i) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (up) state_d = UP;
         UP: begin
            if (down)                                  state_d = DOWN;
            else if (!up || (gain_q + GAIN_ONE == target)) state_d = HOLD;
         end
         HOLD: begin
            if (up)        state_d = UP;
            else if (down) state_d = DOWN;
         end
         DOWN: begin
            if (up)                               state_d = UP;
            else if (!down)                       state_d = (gain_q == '0) ? IDLE : HOLD;
            else if (gain_q - GAIN_ONE == '0)     state_d = IDLE;
            else if (gain_q - GAIN_ONE == target) state_d = HOLD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gain_d = gain_q;
      if (up)        gain_d = gain_q + GAIN_ONE;
      else if (down) gain_d = gain_q - GAIN_ONE;
   end

   // Scaled uses the gain from before this strobe's step
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         gain_q   <= '0;
         scaled_q <= '0;
      end else if (strobe_i) begin
         gain_q   <= gain_d;
         scaled_q <= scaled_d;
      end
   end

   assign scaled_o = scaled_q;
   assign active_o = |gain_q;

endmodule

// File: rtl/ssg_channel_mixer.sv
// Mixes NUM_CH ramped, volume-scaled channels into one sample; optional ChannelOut under SSG_MIX_CHOUT_EN.
// Strobe to MixValid is two edges, one sample per cycle, no backpressure.
module ssg_channel_mixer
   import ssg_mix_pkg::*;
#(
   parameter  int NUM_CH   = 4,
   parameter  int SAMPLE_W = DEF_SAMPLE_W,
   parameter  int VOL_W    = DEF_VOL_W,
   localparam int SUM_W    = SAMPLE_W + $clog2(NUM_CH)
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       sample_strobe_i,
   input  logic [NUM_CH*SAMPLE_W-1:0] waveforms_i,
   input  logic [SAMPLE_W-1:0]        noise_i,
   input  logic [2*NUM_CH-1:0]        status_i,
   input  logic [NUM_CH*VOL_W-1:0]    volume_i,
   output logic [SUM_W-1:0]           mix_out_o,
   output logic                       mix_valid_o,
`ifdef SSG_MIX_CHOUT_EN
   output logic [NUM_CH*SAMPLE_W-1:0] channel_out_o,
`endif
   output logic [NUM_CH-1:0]          channel_active_o
);

   logic [SAMPLE_W-1:0] scaled [NUM_CH];
   logic [SUM_W-1:0]    sum_d;
   logic [SUM_W-1:0]    mix_q;
   logic                vld1_q, mix_vld_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ssg_mix_channel #(
         .SAMPLE_W (SAMPLE_W),
         .VOL_W    (VOL_W)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_n_i  (rst_n_i),
         .strobe_i (sample_strobe_i),
         .wave_i   (waveforms_i[i*SAMPLE_W +: SAMPLE_W]),
         .noise_i  (noise_i),
         .status_i (status_i[2*i +: 2]),
         .volume_i (volume_i[i*VOL_W +: VOL_W]),
         .scaled_o (scaled[i]),
         .active_o (channel_active_o[i])
      );
`ifdef SSG_MIX_CHOUT_EN
      assign channel_out_o[i*SAMPLE_W +: SAMPLE_W] = scaled[i];
`endif
   end

   // SUM_W carries log2(NUM_CH) headroom bits, so the sum cannot wrap
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum_d = sum_d + SUM_W'(scaled[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld1_q    <= 1'b0;
         mix_vld_q <= 1'b0;
         mix_q     <= '0;
      end else begin
         vld1_q    <= sample_strobe_i;
         mix_vld_q <= vld1_q;
         if (vld1_q) begin
            mix_q <= sum_d;
         end
      end
   end

   assign mix_out_o   = mix_q;
   assign mix_valid_o = mix_vld_q;

endmodule

// File: tb/tb_ssg_channel_mixer.sv
// Self-checking bench: directed table, hand sequences and random traffic against a queue-based model.
module tb_ssg_channel_mixer;

   localparam int NUM_CH   = 4;
   localparam int SAMPLE_W = 6;
   localparam int VOL_W    = 4;
   localparam int SUM_W    = 8;

   logic                       clk    = 1'b0;
   logic                       rst_n  = 1'b0;
   logic                       strobe = 1'b0;
   logic [NUM_CH*SAMPLE_W-1:0] wave   = '0;
   logic [SAMPLE_W-1:0]        noise  = '0;
   logic [2*NUM_CH-1:0]        status = '0;
   logic [NUM_CH*VOL_W-1:0]    volume = '0;
   logic [SUM_W-1:0]           mix_out;
   logic                       mix_vld;
   logic [NUM_CH-1:0]          active;
`ifdef SSG_MIX_CHOUT_EN
   logic [NUM_CH*SAMPLE_W-1:0] ch_out;
`endif

   ssg_channel_mixer #(
      .NUM_CH   (NUM_CH),
      .SAMPLE_W (SAMPLE_W),
      .VOL_W    (VOL_W)
   ) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .sample_strobe_i  (strobe),
      .waveforms_i      (wave),
      .noise_i          (noise),
      .status_i         (status),
      .volume_i         (volume),
      .mix_out_o        (mix_out),
      .mix_valid_o      (mix_vld),
`ifdef SSG_MIX_CHOUT_EN
      .channel_out_o    (ch_out),
`endif
      .channel_active_o (active)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int due;
      int val;
   } pend_t;

   pend_t pq[$];
   int    m_gain[NUM_CH];
   int    m_scaled[NUM_CH];
   int    m_mix = 0;
   int    m_vld = 0;
   int    cyc   = 0;

   typedef struct {
      logic       stb;
      logic [7:0] st;
      int         vld;
      int         mix;
      logic [3:0] act;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pq.delete();
      for (int i = 0; i < NUM_CH; i++) begin
         m_gain[i]   = 0;
         m_scaled[i] = 0;
      end
      m_mix = 0;
      m_vld = 0;
   endtask

   // Spec-level model: each strobe yields one mix result due one edge later
   task automatic model_edge();
      int sum, s, tgt;
      cyc++;
      m_vld = 0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
         m_vld = 1;
         m_mix = pq[0].val;
         void'(pq.pop_front());
      end
      if (strobe) begin
         sum = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!status[2*i+1])   s = 0;
            else if (status[2*i]) s = int'(noise);
            else                  s = int'(wave[i*SAMPLE_W +: SAMPLE_W]);
            m_scaled[i] = (s * m_gain[i]) / 16;
            sum += m_scaled[i];
            tgt = status[2*i+1] ? int'(volume[i*VOL_W +: VOL_W]) : 0;
            if (tgt > m_gain[i])      m_gain[i]++;
            else if (tgt < m_gain[i]) m_gain[i]--;
         end
         pq.push_back('{cyc + 1, sum});
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] ea;
      for (int i = 0; i < NUM_CH; i++) ea[i] = (m_gain[i] != 0);
      chk({tag, "_mix_valid"}, int'(mix_vld), m_vld);
      chk({tag, "_mix_out"}, int'(mix_out), m_mix);
      chk({tag, "_active"}, int'(active), int'(ea));
`ifdef SSG_MIX_CHOUT_EN
      for (int i = 0; i < NUM_CH; i++)
         chk($sformatf("%s_chout%0d", tag, i), int'(ch_out[i*SAMPLE_W +: SAMPLE_W]), m_scaled[i]);
`endif
   endtask

   task automatic tick(input logic stb, input logic [7:0] st, input logic [15:0] vol,
                       input logic [23:0] wv, input logic [5:0] nz, input string tag);
      strobe = stb;
      status = st;
      volume = vol;
      wave   = wv;
      noise  = nz;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int cnt;
      logic [7:0]  r_st;
      logic [15:0] r_vol;

      // ch0 waveform 63 at volume 15; strobes, gaps, then disable and ramp out
      tbl[0]  = '{1'b1, 8'h02, 0,  0, 4'h1};
      tbl[1]  = '{1'b1, 8'h02, 1,  0, 4'h1};
      tbl[2]  = '{1'b1, 8'h02, 1,  3, 4'h1};
      tbl[3]  = '{1'b1, 8'h02, 1,  7, 4'h1};
      tbl[4]  = '{1'b0, 8'h02, 1, 11, 4'h1};
      tbl[5]  = '{1'b0, 8'h02, 0, 11, 4'h1};
      tbl[6]  = '{1'b1, 8'h02, 0, 11, 4'h1};
      tbl[7]  = '{1'b1, 8'h00, 1, 15, 4'h1};
      tbl[8]  = '{1'b1, 8'h00, 1,  0, 4'h1};
      tbl[9]  = '{1'b1, 8'h00, 1,  0, 4'h1};
      tbl[10] = '{1'b1, 8'h00, 1,  0, 4'h1};
      tbl[11] = '{1'b1, 8'h00, 1,  0, 4'h0};
      tbl[12] = '{1'b0, 8'h00, 1,  0, 4'h0};
      tbl[13] = '{1'b0, 8'h00, 0,  0, 4'h0};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("in_reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 20; k++) tick(1'b0, 8'h00, 16'h0000, 24'h0, 6'h0, "idle");

      for (int k = 0; k < 14; k++) begin
         tick(tbl[k].stb, tbl[k].st, 16'h000F, 24'd63, 6'd0, "tblm");
         chk($sformatf("tbl%0d_vld", k), int'(mix_vld), tbl[k].vld);
         chk($sformatf("tbl%0d_mix", k), int'(mix_out), tbl[k].mix);
         chk($sformatf("tbl%0d_act", k), int'(active), int'(tbl[k].act));
      end

      // ch1 ramps to gain 5 toward volume 8, then is disabled and ramps out
      for (int k = 0; k < 5; k++) tick(1'b1, 8'h08, 16'h0080, 24'h3F << 6, 6'd0, "ch1up");
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 8'h00, 16'h0080, 24'h3F << 6, 6'd0, "ch1dn");
         chk($sformatf("ch1_active_step%0d", k), int'(active[1]), 1);
      end
      chk("ch1_mix_silent", int'(mix_out), 0);
      tick(1'b1, 8'h00, 16'h0080, 24'h3F << 6, 6'd0, "ch1dn");
      chk("ch1_active_cleared", int'(active[1]), 0);

      // all channels on noise 63 at full volume
      for (int k = 0; k < 20; k++) tick(1'b1, 8'hFF, 16'hFFFF, 24'h0, 6'd63, "allnz");
      tick(1'b0, 8'hFF, 16'hFFFF, 24'h0, 6'd63, "allnz");
      chk("all_noise_mix", int'(mix_out), 236);

      // back-to-back strobes produce one valid per strobe
      repeat (3) tick(1'b0, 8'hFF, 16'hFFFF, 24'h0, 6'd63, "b2b");
      cnt = 0;
      for (int k = 0; k < 13; k++) begin
         tick(k < 10, 8'hFF, 16'hFFFF, 24'h0, 6'd63, "b2b");
         if (mix_vld) cnt++;
      end
      chk("b2b_valid_count", cnt, 10);

      // ramp down toward 8, then reset asynchronously mid-ramp
      repeat (3) tick(1'b1, 8'hFF, 16'h8888, 24'h0, 6'd63, "rdn");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b1, 8'hFF, 16'h8888, 24'h0, 6'd63, "post_rst");
      chk("post_reset_active", int'(active), 15);
      tick(1'b1, 8'hFF, 16'h8888, 24'h0, 6'd63, "post_rst");
      chk("post_reset_first_mix", int'(mix_out), 0);
      tick(1'b1, 8'hFF, 16'h8888, 24'h0, 6'd63, "post_rst");
      chk("post_reset_second_mix", int'(mix_out), 12);

      // random traffic with slowly changing controls so ramps run long
      r_st  = 8'hFF;
      r_vol = 16'hFFFF;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) r_st  = 8'($urandom);
         if ($urandom_range(0, 9) == 0) r_vol = 16'($urandom);
         tick($urandom_range(0, 9) < 6, r_st, r_vol, 24'($urandom), 6'($urandom), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
